// File: rtl/mem_access.sv
// MEM stage: RISC-V loads/stores as little-endian byte transactions on a byte port.
// Define MEM_ACCESS_FAST_DONE_EN to finish in the final-ack cycle instead of DONE.
module mem_access #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [REG_ADDR_W-1:0] mem_wd_i,
  input  logic                  mem_wreg_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  input  logic                  mem_ld_i,
  input  logic                  mem_st_i,
  input  logic [2:0]            mem_funct3_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_sdata_i,
  output logic                  mc_req,
  output logic                  mc_we,
  output logic [ADDR_W-1:0]     mc_addr,
  output logic [7:0]            mc_wdata,
  input  logic [7:0]            mc_rdata,
  input  logic                  mc_ack,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  stall_req
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state;
  logic [1:0]            cnt;
  logic [REG_ADDR_W-1:0] wd_q;
  logic                  wreg_q;
  logic                  ld_q;
  logic                  st_q;
  logic [2:0]            f3_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     sdata_q;
  logic [DATA_W-1:0]     rbuf;
  logic [DATA_W-1:0]     res_buf;
  logic [1:0]            last;
  logic                  fin;

  function automatic logic [DATA_W-1:0] ext(
    input logic [2:0]        f3,
    input logic [DATA_W-1:0] b
  );
    case (f3)
      3'b000:  ext = {{24{b[7]}}, b[7:0]};
      3'b001:  ext = {{16{b[15]}}, b[15:0]};
      3'b100:  ext = {24'b0, b[7:0]};
      3'b101:  ext = {16'b0, b[15:0]};
      default: ext = b;
    endcase
  endfunction

  assign last = (f3_q[1:0] == 2'b00) ? 2'd0 :
                (f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
  assign fin  = rdy && mc_ack && (cnt == last);

`ifdef MEM_ACCESS_FAST_DONE_EN
  // final byte is not in rbuf yet; splice it in from the port
  always_comb begin
    res_buf = rbuf;
    res_buf[{cnt, 3'b000} +: 8] = mc_rdata;
  end
`else
  assign res_buf = rbuf;
`endif

  always_comb begin
    mc_req    = 1'b0;
    mc_we     = 1'b0;
    mc_addr   = '0;
    mc_wdata  = '0;
    mem_wd    = '0;
    mem_wreg  = 1'b0;
    mem_wdata = '0;
    stall_req = 1'b0;
    if (rst) begin
      unique case (state)
        IDLE: begin
          if (mem_ld_i || mem_st_i) begin
            stall_req = 1'b1;
          end else begin
            mem_wd    = mem_wd_i;
            mem_wreg  = mem_wreg_i;
            mem_wdata = mem_wdata_i;
          end
        end
        ACCESS: begin
          mc_req    = rdy;
          mc_we     = st_q;
          mc_addr   = addr_q + ADDR_W'(cnt);
          mc_wdata  = sdata_q[{cnt, 3'b000} +: 8];
          stall_req = 1'b1;
`ifdef MEM_ACCESS_FAST_DONE_EN
          if (fin) begin
            stall_req = 1'b0;
            mem_wd    = wd_q;
            mem_wreg  = wreg_q;
            mem_wdata = ld_q ? ext(f3_q, res_buf) : '0;
          end
`endif
        end
        DONE: begin
          mem_wd    = wd_q;
          mem_wreg  = wreg_q;
          mem_wdata = ld_q ? ext(f3_q, res_buf) : '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      rbuf    <= '0;
    end else if (rdy) begin
      unique case (state)
        IDLE: begin
          if (mem_ld_i || mem_st_i) begin
            wd_q    <= mem_wd_i;
            wreg_q  <= mem_ld_i ? mem_wreg_i : 1'b0;
            ld_q    <= mem_ld_i;
            st_q    <= mem_st_i & ~mem_ld_i;
            f3_q    <= mem_funct3_i;
            addr_q  <= mem_addr_i;
            sdata_q <= mem_sdata_i;
            rbuf    <= '0;
            cnt     <= '0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (mc_ack) begin
            if (ld_q) rbuf[{cnt, 3'b000} +: 8] <= mc_rdata;
            if (fin) begin
              cnt <= '0;
`ifdef MEM_ACCESS_FAST_DONE_EN
              state <= IDLE;
`else
              state <= DONE;
`endif
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access.
// Byte-wide memory controller model with random ack delay and rdy gaps.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic [4:0]  mem_wd_i = '0;
  logic        mem_wreg_i = 1'b0;
  logic [31:0] mem_wdata_i = '0;
  logic        mem_ld_i = 1'b0;
  logic        mem_st_i = 1'b0;
  logic [2:0]  mem_funct3_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_sdata_i = '0;
  logic        mc_req;
  logic        mc_we;
  logic [31:0] mc_addr;
  logic [7:0]  mc_wdata;
  logic [7:0]  mc_rdata = '0;
  logic        mc_ack = 1'b0;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stall_req;

  mem_access dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i),
    .mem_wdata_i(mem_wdata_i), .mem_ld_i(mem_ld_i),
    .mem_st_i(mem_st_i), .mem_funct3_i(mem_funct3_i),
    .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
    .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_rdata(mc_rdata), .mc_ack(mc_ack),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] alu;
  } ins_t;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } res_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } acc_t;

  logic [7:0] mem [0:1023];
  logic [7:0] ref_mem [0:1023];
  res_t exp_q[$];
  acc_t acc_q[$];
  ins_t dq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop = 0;
  bit   mon_en = 1'b0;
  bit   ctl_pend = 1'b0;

  task automatic check(input string nm, input logic [95:0] act,
                       input logic [95:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic ins_t mk(input logic ld, input logic st,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [4:0] wd,
                              input logic wreg, input logic [31:0] alu);
    mk = '{ld, st, f3, a, sd, wd, wreg, alu};
  endfunction

  function automatic ins_t rand_ins();
    int k;
    logic [31:0] a;
    k = $urandom_range(0, 9);
    if ($urandom_range(0, 7) == 0)
      a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    else
      a = 32'($urandom_range(0, 1023));
    rand_ins = mk((k >= 4 && k < 7) || k == 9, k >= 7, 3'($urandom), a,
                  $urandom, 5'($urandom), 1'($urandom), $urandom);
  endfunction

  // Reference: a load returns the N bytes at a..a+N-1, a store overwrites them.
  task automatic issue(input ins_t i);
    int n;
    logic [31:0] v;
    logic [31:0] ea;
    logic [31:0] r;
    logic [7:0]  b;
    mem_wd_i     = i.wd;
    mem_wreg_i   = i.wreg;
    mem_wdata_i  = i.alu;
    mem_ld_i     = i.ld;
    mem_st_i     = i.st;
    mem_funct3_i = i.f3;
    mem_addr_i   = i.a;
    mem_sdata_i  = i.sd;
    if (i.ld || i.st) begin
      n = (i.f3 % 4 == 0) ? 1 : (i.f3 % 4 == 1) ? 2 : 4;
      v = '0;
      for (int j = 0; j < n; j++) begin
        ea = i.a + 32'(j);
        if (i.ld) begin
          v = v | (32'(ref_mem[ea[9:0]]) << (8 * j));
          acc_q.push_back('{1'b0, ea, 8'h00});
        end else begin
          b = 8'(i.sd >> (8 * j));
          ref_mem[ea[9:0]] = b;
          acc_q.push_back('{1'b1, ea, b});
        end
      end
      if (i.ld) begin
        r = v;
        if (i.f3 == 3'd0 && v[7])  r = v | 32'hFFFF_FF00;
        if (i.f3 == 3'd1 && v[15]) r = v | 32'hFFFF_0000;
        exp_q.push_back('{i.wd, i.wreg, r});
      end else begin
        exp_q.push_back('{i.wd, 1'b0, 32'h0});
      end
    end else begin
      exp_q.push_back('{i.wd, i.wreg, i.alu});
    end
  endtask

  function automatic logic [80:0] all_outs();
    all_outs = {mc_req, mc_we, mc_addr, mc_wdata, mem_wd, mem_wreg,
                mem_wdata, stall_req};
  endfunction

  // ex_mem model: advance to the next instruction whenever the stage is not stalled
  initial begin
    bit adv;
    forever begin
      @(negedge clk);
      adv = rst && rdy && !stall_req;
      @(posedge clk);
      #1;
      if (adv) begin
        if (dq.size() > 0) issue(dq.pop_front());
        else issue(rand_ins());
      end
    end
  end

  // mem_wb side monitor
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rst) begin
        if (stall_req) begin
          check("stall_wreg", 96'(mem_wreg), 96'(0));
        end else if (rdy) begin
          if (exp_q.size() == 0) begin
            fail_now("result_unexpected");
          end else begin
            e = exp_q.pop_front();
            check("result", 96'({mem_wd, mem_wreg, mem_wdata}), 96'(e));
            n_pop++;
          end
        end
      end
    end
  end

  // memory controller: random ack delay, random rdy gaps, no ack while rdy=0
  initial begin
    int   wait_cnt;
    acc_t cur;
    acc_t e;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst && !mc_ack && mc_req && !ctl_pend) begin
        if (wait_cnt == 0) begin
          ctl_pend = 1'b1;
          cur = '{mc_we, mc_addr, mc_wdata};
        end else begin
          wait_cnt--;
        end
      end
      @(posedge clk);
      #1;
      rdy = ($urandom_range(0, 9) != 0);
      if (ctl_pend && rdy && rst) begin
        ctl_pend = 1'b0;
        wait_cnt = $urandom_range(0, 3);
        mc_ack = 1'b1;
        mc_rdata = cur.we ? 8'($urandom) : mem[cur.addr[9:0]];
        if (cur.we) mem[cur.addr[9:0]] = cur.wdata;
        if (acc_q.size() == 0) begin
          fail_now("access_unexpected");
        end else begin
          e = acc_q.pop_front();
          check("access_we", 96'(cur.we), 96'(e.we));
          check("access_addr", 96'(cur.addr), 96'(e.addr));
          if (e.we) check("access_wdata", 96'(cur.wdata), 96'(e.wdata));
        end
      end else begin
        mc_ack = 1'b0;
        mc_rdata = 8'($urandom);
      end
    end
  end

  initial begin
    int t;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[10'h100] = 8'h80;
    mem[10'h203] = 8'h11;
    mem[10'h204] = 8'h22;
    mem[10'h205] = 8'h33;
    mem[10'h206] = 8'h44;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    dq.push_back(mk(0, 0, 3'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234));
    dq.push_back(mk(1, 0, 3'd0, 32'h100, 32'h0, 5'd6, 1'b1, 32'h0));
    dq.push_back(mk(1, 0, 3'd4, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0));
    dq.push_back(mk(1, 0, 3'd2, 32'h203, 32'h0, 5'd8, 1'b1, 32'h0));
    dq.push_back(mk(0, 1, 3'd1, 32'h10, 32'hAABBCCDD, 5'd9, 1'b1, 32'h0));
    dq.push_back(mk(1, 0, 3'd2, 32'h10, 32'h0, 5'd10, 1'b1, 32'h0));
    dq.push_back(mk(0, 1, 3'd2, 32'hFFFF_FFFE, 32'h01020304, 5'd11, 1'b0, 32'h0));
    dq.push_back(mk(1, 0, 3'd2, 32'hFFFF_FFFE, 32'h0, 5'd12, 1'b1, 32'h0));
    dq.push_back(mk(1, 1, 3'd5, 32'h204, 32'h0, 5'd13, 1'b1, 32'h0));
    mem_wd_i = 5'd3;
    mem_wreg_i = 1'b1;
    mem_wdata_i = 32'hDEAD_BEEF;
    #12;
    check("reset_outs", 96'(all_outs()), 96'(0));
    @(posedge clk);
    #1;
    issue(dq.pop_front());
    mon_en = 1'b1;
    #2;
    rst = 1'b1;

    t = 0;
    while (n_pop < 60 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 20000) fail_now("timeout_phase1");

    // abandon an access after at least one byte has completed
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(mc_req && mc_addr != mem_addr_i) && t < 5000);
    if (t >= 5000) fail_now("timeout_midop");
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midop_reset_outs", 96'(all_outs()), 96'(0));
    exp_q.delete();
    acc_q.delete();
    ctl_pend = 1'b0;
    mc_ack = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    issue(mk(1, 0, 3'd2, 32'($urandom_range(0, 1023)), 32'h0,
             5'd21, 1'b1, 32'h0));
    @(posedge clk);
    #1;
    check("held_reset_outs", 96'(all_outs()), 96'(0));
    #2;
    rst = 1'b1;

    t = 0;
    while (n_pop < 300 && t < 40000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 40000) fail_now("timeout_phase2");
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
